rename: RTL and testbench
=========================

RENAME -- requirements
Module: rename

Interface
REQ-001 Parameter OPW, default 32, width of the opaque decoded-op payload carried through unchanged.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 decode_rename_valid  in  1  decoded instruction offered.
REQ-005 decode_rename_rd  in  6  bit5 = writes register, [4:0] = arch rd.
REQ-006 decode_rename_rs1 / decode_rename_rs2  in  5 each  arch sources.
REQ-007 decode_rename_op  in  OPW  payload.
REQ-008 rename_stall  out  1  decode SHALL hold its inputs stable while asserted.
REQ-009 rename_rat_valid  out  1; rename_rat_rd out 6; rename_rat_robid out 8; rename_rat_rs1 / rename_rat_rs2 out 5 each: RAT rename/lookup port.
REQ-010 rat_rs1_valid / rat_rs2_valid  in  1; rat_rs1_tagval / rat_rs2_tagval  in  32: RAT lookup result, valid the cycle after the address is presented.
REQ-011 rename_rob_valid  out  1; rename_rob_rd  out  6; rename_rob_robid  out  8: ROB allocation.
REQ-012 rob_rename_full  in  1; rob_flush  in  1.
REQ-013 wb_valid  in  1; wb_error  in  1; wb_robid  in  8; wb_result  in  32: writeback snoop.
REQ-014 rename_dispatch_valid out 1; rename_dispatch_robid out 8; rename_dispatch_rd out 6; rename_dispatch_op out OPW; rename_dispatch_rs1_valid / rs2_valid out 1; rename_dispatch_rs1_tagval / rs2_tagval out 32.
REQ-015 dispatch_stall  in  1  dispatch cannot accept this cycle.

Function
REQ-016 accept = decode_rename_valid & ~rename_stall & ~rob_flush.
REQ-017 rename_stall = rob_rename_full | (S1 valid & dispatch_stall).
REQ-018 Allocation counter: 8-bit; each accept assigns the current value as robid, then increments it, wrapping 255->0.
REQ-019 rename_rob_valid = accept; rename_rob_rd and rename_rob_robid are the accepted rd and the assigned robid, same cycle.
REQ-020 rename_rat_rs1 / rename_rat_rs2 are driven from the decode sources combinationally every cycle.
REQ-021 rename_rat_valid = accept & rd[5] & (rd[4:0] != 0); rename_rat_rd and rename_rat_robid carry the rd and the assigned robid.
REQ-022 A source read and a same-instruction rd write in the same cycle SHALL return the pre-write mapping; rename SHALL add no bypass for this case.
REQ-023 S1 (single-entry) loads robid, rd, op and the arch sources on accept.
REQ-024 S1 first cycle (the cycle after accept): operand outputs pass the RAT result through combinationally. At the end of that cycle, S1 latches those values into operand registers.
REQ-025 S1 later cycles: operand outputs come from the operand registers.
REQ-026 Arch source 0: operand forced valid=1, tagval=0, regardless of RAT.
REQ-027 Wakeup: if an operand is invalid and wb_valid & ~wb_error & (wb_robid[6:0] == tag[6:0]), set it valid with tagval=wb_result.
- Applies in the S1 first cycle (combinational onto outputs and latched) and in every held cycle.
REQ-028 wb_error=1 SHALL never wake an operand.
REQ-029 rename_dispatch_valid = S1 valid; S1 drains when valid & ~dispatch_stall.
- Simultaneous drain and accept reload S1 with the new instruction, giving back-to-back throughput of 1 per cycle.
REQ-030 Latency: accept in cycle N gives rename_dispatch_valid in cycle N+1.
REQ-031 rob_flush in cycle N:
- S1 invalidated at end of N.
- Allocation counter set to 0.
- No accept, RAT write or ROB allocation occurs in N.
- rename_dispatch_valid SHALL be 0 in N+1.
REQ-032 rob_rename_full blocks accept only; S1 continues to drain.

Reset
REQ-033 rst clears S1 valid and sets the allocation counter to 0.
REQ-034 During and after reset, rename_dispatch_valid, rename_rat_valid and rename_rob_valid are 0 until the first accept.
REQ-035 Reset mid-operation discards any S1 content with no dispatch.

Verification
REQ-036 Reset, then decode rd=0x25, rs1=3, rs2=0 with RAT rs1 returning valid=0, tag=0x04:
- Cycle 0: rename_rat_valid=1, robid=0x00.
- Cycle 1: dispatch valid, rs1_valid=0 / tagval=0x04, rs2_valid=1 / tagval=0.
REQ-037 Hold dispatch_stall=1 for 3 cycles with an rs1 tag of 0x04, pulse wb_valid robid=0x04 result=0xDEADBEEF:
- rename_stall=1 throughout the stall.
- rs1 becomes valid with 0xDEADBEEF the same cycle as the pulse.
- The instruction dispatches once, after the stall releases.
REQ-038 Same as REQ-037 with wb_error=1: rs1 stays invalid with tagval 0x04.
REQ-039 Stream 257 accepts with no stalls:
- robids run 0x00..0xFF then 0x00.
- One dispatch per cycle.
REQ-040 rob_flush while S1 is valid and decode_rename_valid=1:
- No RAT or ROB write that cycle.
- Dispatch valid 0 the next cycle.
- The next accepted instruction gets robid 0x00.
REQ-041 rob_rename_full=1 with S1 valid and dispatch_stall=0: S1 dispatches, no new accept, rename_stall=1.

Source files
------------

// File: rtl/rename.sv
// ---------------------------------------------------------------------------
// rename -- register rename stage between decode and dispatch.
//
// Purpose
//   Takes one decoded instruction per cycle and gives it a ROB id from a
//   wrapping 8-bit allocation counter. It reads the source mappings from the
//   RAT and writes the destination mapping into the RAT. It allocates the ROB
//   entry and then holds the instruction in a single-entry stage (S1) until
//   dispatch accepts it. While the instruction waits in S1, its operands
//   snoop the writeback bus.
//
// Handshake (valid/ready)
//   Decode offers an instruction with decode_rename_valid. rename_stall acts
//   as an inverted ready. An instruction is accepted in a cycle when it is
//   valid, rename_stall is low and rob_flush is low. Decode keeps its inputs
//   stable while rename_stall is high. On the dispatch side,
//   rename_dispatch_valid is the offer and dispatch_stall is the inverted
//   ready. S1 leaves when it is valid and dispatch_stall is low. A drain and
//   an accept in the same cycle reload S1, which gives one instruction per
//   cycle.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   decode_rename_*               decoded instruction in (rd[5] = writes rd)
//   rename_stall                  back-pressure to decode
//   rename_rat_*                  RAT lookup addresses and rename write
//   rat_rs1_*/rat_rs2_*           RAT lookup result, one cycle after address
//   rename_rob_*                  ROB allocation
//   rob_rename_full, rob_flush    ROB back-pressure and pipeline flush
//   wb_*                          writeback snoop for operand wakeup
//   rename_dispatch_*             renamed instruction out
//   dispatch_stall                back-pressure from dispatch
//   dbg_s1_valid, dbg_s1_first    S1 occupancy state, for observation
// ---------------------------------------------------------------------------
module rename #(
  parameter int OPW = 32
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           decode_rename_valid,
  input  logic [5:0]     decode_rename_rd,
  input  logic [4:0]     decode_rename_rs1,
  input  logic [4:0]     decode_rename_rs2,
  input  logic [OPW-1:0] decode_rename_op,
  output logic           rename_stall,

  output logic           rename_rat_valid,
  output logic [5:0]     rename_rat_rd,
  output logic [7:0]     rename_rat_robid,
  output logic [4:0]     rename_rat_rs1,
  output logic [4:0]     rename_rat_rs2,
  input  logic           rat_rs1_valid,
  input  logic [31:0]    rat_rs1_tagval,
  input  logic           rat_rs2_valid,
  input  logic [31:0]    rat_rs2_tagval,

  output logic           rename_rob_valid,
  output logic [5:0]     rename_rob_rd,
  output logic [7:0]     rename_rob_robid,
  input  logic           rob_rename_full,
  input  logic           rob_flush,

  input  logic           wb_valid,
  input  logic           wb_error,
  input  logic [7:0]     wb_robid,
  input  logic [31:0]    wb_result,

  output logic           rename_dispatch_valid,
  output logic [7:0]     rename_dispatch_robid,
  output logic [5:0]     rename_dispatch_rd,
  output logic [OPW-1:0] rename_dispatch_op,
  output logic           rename_dispatch_rs1_valid,
  output logic [31:0]    rename_dispatch_rs1_tagval,
  output logic           rename_dispatch_rs2_valid,
  output logic [31:0]    rename_dispatch_rs2_tagval,
  input  logic           dispatch_stall,

  output logic           dbg_s1_valid,
  output logic           dbg_s1_first
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0]     r_alloc;       // next ROB id to hand out
  logic           r_s1_valid;
  logic           r_s1_first;    // S1 was loaded last cycle; RAT result is live
  logic [7:0]     r_s1_robid;
  logic [5:0]     r_s1_rd;
  logic [OPW-1:0] r_s1_op;
  logic [4:0]     r_s1_rs1;
  logic [4:0]     r_s1_rs2;
  logic           r_op1_valid;
  logic [31:0]    r_op1_tagval;
  logic           r_op2_valid;
  logic [31:0]    r_op2_tagval;

  logic           w_stall;
  logic           w_accept;
  logic           w_drain;
  logic [32:0]    w_op1;         // {valid, tagval}
  logic [32:0]    w_op2;

  // -------------------------------------------------------------------------
  // Operand resolution. In the first cycle the RAT answer is used directly.
  // After that the operand registers are used. Arch register 0 is always a
  // ready zero. A pending tag wakes up when a non-error writeback matches it
  // on the low 7 bits.
  // -------------------------------------------------------------------------
  function automatic logic [32:0] f_resolve(
    input logic        first,
    input logic [4:0]  src,
    input logic        rat_v,
    input logic [31:0] rat_tv,
    input logic        reg_v,
    input logic [31:0] reg_tv,
    input logic        wbv,
    input logic        wbe,
    input logic [7:0]  wbid,
    input logic [31:0] wbres
  );
    logic        v;
    logic [31:0] tv;
    if (first) begin
      if (src == 5'd0) begin
        v  = 1'b1;
        tv = 32'd0;
      end else begin
        v  = rat_v;
        tv = rat_tv;
      end
    end else begin
      v  = reg_v;
      tv = reg_tv;
    end
    if (!v && wbv && !wbe && (wbid[6:0] == tv[6:0])) begin
      v  = 1'b1;
      tv = wbres;
    end
    return {v, tv};
  endfunction

  always_comb begin
    w_op1 = f_resolve(r_s1_first, r_s1_rs1, rat_rs1_valid, rat_rs1_tagval,
                      r_op1_valid, r_op1_tagval,
                      wb_valid, wb_error, wb_robid, wb_result);
    w_op2 = f_resolve(r_s1_first, r_s1_rs2, rat_rs2_valid, rat_rs2_tagval,
                      r_op2_valid, r_op2_tagval,
                      wb_valid, wb_error, wb_robid, wb_result);
  end

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign w_stall  = rob_rename_full | (r_s1_valid & dispatch_stall);
  // rst is included so that no RAT or ROB write escapes while in reset.
  assign w_accept = decode_rename_valid & ~w_stall & ~rob_flush & ~rst;
  assign w_drain  = r_s1_valid & ~dispatch_stall;

  assign rename_stall = w_stall;

  // RAT port. The lookup addresses follow decode every cycle. Because the
  // RAT answers one cycle later, a source that names this instruction's own
  // rd sees the older mapping, and no bypass is needed.
  assign rename_rat_rs1   = decode_rename_rs1;
  assign rename_rat_rs2   = decode_rename_rs2;
  assign rename_rat_valid = w_accept & decode_rename_rd[5] &
                            (decode_rename_rd[4:0] != 5'd0);
  assign rename_rat_rd    = decode_rename_rd;
  assign rename_rat_robid = r_alloc;

  // ROB allocation
  assign rename_rob_valid = w_accept;
  assign rename_rob_rd    = decode_rename_rd;
  assign rename_rob_robid = r_alloc;

  // Dispatch. S1 contents are hidden while reset is asserted.
  assign rename_dispatch_valid      = r_s1_valid & ~rst;
  assign rename_dispatch_robid      = r_s1_robid;
  assign rename_dispatch_rd         = r_s1_rd;
  assign rename_dispatch_op         = r_s1_op;
  assign rename_dispatch_rs1_valid  = w_op1[32];
  assign rename_dispatch_rs1_tagval = w_op1[31:0];
  assign rename_dispatch_rs2_valid  = w_op2[32];
  assign rename_dispatch_rs2_tagval = w_op2[31:0];

  assign dbg_s1_valid = r_s1_valid;
  assign dbg_s1_first = r_s1_first;

  // -------------------------------------------------------------------------
  // Control state: allocation counter and S1 occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc    <= 8'd0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
    end else if (rob_flush) begin
      r_alloc    <= 8'd0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
    end else if (w_accept) begin
      // If S1 is full, accept implies ~dispatch_stall, so S1 drains now.
      r_alloc    <= r_alloc + 8'd1;
      r_s1_valid <= 1'b1;
      r_s1_first <= 1'b1;
    end else begin
      if (w_drain) begin
        r_s1_valid <= 1'b0;
      end
      r_s1_first <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: instruction fields on accept, and operand capture every cycle
  // S1 is occupied. The capture freezes the RAT answer after the first
  // cycle and keeps any wakeup seen on the writeback bus.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_robid <= r_alloc;
      r_s1_rd    <= decode_rename_rd;
      r_s1_op    <= decode_rename_op;
      r_s1_rs1   <= decode_rename_rs1;
      r_s1_rs2   <= decode_rename_rs2;
    end
    if (r_s1_valid) begin
      r_op1_valid  <= w_op1[32];
      r_op1_tagval <= w_op1[31:0];
      r_op2_valid  <= w_op2[32];
      r_op2_tagval <= w_op2[31:0];
    end
  end

endmodule

// File: tb/tb_rename.sv
module tb_rename;
  localparam int OPW = 32;

  logic           clk;
  logic           rst;
  logic           decode_rename_valid;
  logic [5:0]     decode_rename_rd;
  logic [4:0]     decode_rename_rs1;
  logic [4:0]     decode_rename_rs2;
  logic [OPW-1:0] decode_rename_op;
  logic           rename_stall;
  logic           rename_rat_valid;
  logic [5:0]     rename_rat_rd;
  logic [7:0]     rename_rat_robid;
  logic [4:0]     rename_rat_rs1;
  logic [4:0]     rename_rat_rs2;
  logic           rat_rs1_valid;
  logic [31:0]    rat_rs1_tagval;
  logic           rat_rs2_valid;
  logic [31:0]    rat_rs2_tagval;
  logic           rename_rob_valid;
  logic [5:0]     rename_rob_rd;
  logic [7:0]     rename_rob_robid;
  logic           rob_rename_full;
  logic           rob_flush;
  logic           wb_valid;
  logic           wb_error;
  logic [7:0]     wb_robid;
  logic [31:0]    wb_result;
  logic           rename_dispatch_valid;
  logic [7:0]     rename_dispatch_robid;
  logic [5:0]     rename_dispatch_rd;
  logic [OPW-1:0] rename_dispatch_op;
  logic           rename_dispatch_rs1_valid;
  logic [31:0]    rename_dispatch_rs1_tagval;
  logic           rename_dispatch_rs2_valid;
  logic [31:0]    rename_dispatch_rs2_tagval;
  logic           dispatch_stall;
  logic           dbg_s1_valid;
  logic           dbg_s1_first;

  int checks = 0;
  int errors = 0;

  rename #(.OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .decode_rename_valid(decode_rename_valid), .decode_rename_rd(decode_rename_rd),
    .decode_rename_rs1(decode_rename_rs1), .decode_rename_rs2(decode_rename_rs2),
    .decode_rename_op(decode_rename_op), .rename_stall(rename_stall),
    .rename_rat_valid(rename_rat_valid), .rename_rat_rd(rename_rat_rd),
    .rename_rat_robid(rename_rat_robid), .rename_rat_rs1(rename_rat_rs1),
    .rename_rat_rs2(rename_rat_rs2),
    .rat_rs1_valid(rat_rs1_valid), .rat_rs1_tagval(rat_rs1_tagval),
    .rat_rs2_valid(rat_rs2_valid), .rat_rs2_tagval(rat_rs2_tagval),
    .rename_rob_valid(rename_rob_valid), .rename_rob_rd(rename_rob_rd),
    .rename_rob_robid(rename_rob_robid),
    .rob_rename_full(rob_rename_full), .rob_flush(rob_flush),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid), .wb_result(wb_result),
    .rename_dispatch_valid(rename_dispatch_valid), .rename_dispatch_robid(rename_dispatch_robid),
    .rename_dispatch_rd(rename_dispatch_rd), .rename_dispatch_op(rename_dispatch_op),
    .rename_dispatch_rs1_valid(rename_dispatch_rs1_valid),
    .rename_dispatch_rs1_tagval(rename_dispatch_rs1_tagval),
    .rename_dispatch_rs2_valid(rename_dispatch_rs2_valid),
    .rename_dispatch_rs2_tagval(rename_dispatch_rs2_tagval),
    .dispatch_stall(dispatch_stall),
    .dbg_s1_valid(dbg_s1_valid), .dbg_s1_first(dbg_s1_first)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge. Outputs are sampled on
  // the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_decode(input logic v, input logic [5:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] op);
    decode_rename_valid = v;
    decode_rename_rd    = rd;
    decode_rename_rs1   = rs1;
    decode_rename_rs2   = rs2;
    decode_rename_op    = op;
  endtask

  task automatic drive_rat(input logic v1, input logic [31:0] t1,
                           input logic v2, input logic [31:0] t2);
    rat_rs1_valid = v1; rat_rs1_tagval = t1;
    rat_rs2_valid = v2; rat_rs2_tagval = t2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_decode(1'b1, 6'h25, 5'd3, 5'd4, 32'h0);
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid got %b exp 0", rename_dispatch_valid); end
      checks++; if (rename_rat_valid !== 1'b0) begin errors++; $display("FAIL reset_rat_valid got %b exp 0", rename_rat_valid); end
      checks++; if (rename_rob_valid !== 1'b0) begin errors++; $display("FAIL reset_rob_valid got %b exp 0", rename_rob_valid); end
      next_cycle();
    end
    rst = 1'b0;
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    sample();
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL post_reset_disp_valid got %b exp 0", rename_dispatch_valid); end
    checks++; if (rename_stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got %b exp 0", rename_stall); end
    next_cycle();
  endtask

  // Example instruction: rd=0x25, rs1=3, rs2=0, robid 0
  task automatic test_basic();
    drive_decode(1'b1, 6'h25, 5'd3, 5'd0, 32'h0000_1234);
    sample();
    checks++; if (rename_rat_valid !== 1'b1) begin errors++; $display("FAIL basic_rat_valid got %b exp 1", rename_rat_valid); end
    checks++; if (rename_rat_robid !== 8'h00) begin errors++; $display("FAIL basic_rat_robid got %h exp 00", rename_rat_robid); end
    checks++; if (rename_rat_rd !== 6'h25) begin errors++; $display("FAIL basic_rat_rd got %h exp 25", rename_rat_rd); end
    checks++; if (rename_rat_rs1 !== 5'd3) begin errors++; $display("FAIL basic_rat_rs1 got %0d exp 3", rename_rat_rs1); end
    checks++; if (rename_rob_valid !== 1'b1 || rename_rob_robid !== 8'h00 || rename_rob_rd !== 6'h25) begin errors++; $display("FAIL basic_rob got v=%b id=%h rd=%h exp v=1 id=00 rd=25", rename_rob_valid, rename_rob_robid, rename_rob_rd); end
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL basic_disp_early got %b exp 0", rename_dispatch_valid); end
    next_cycle();
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    drive_rat(1'b0, 32'h4, 1'b1, 32'h99);
    sample();
    checks++; if (rename_dispatch_valid !== 1'b1) begin errors++; $display("FAIL basic_disp_valid got %b exp 1", rename_dispatch_valid); end
    checks++; if (rename_dispatch_robid !== 8'h00 || rename_dispatch_rd !== 6'h25 || rename_dispatch_op !== 32'h1234) begin errors++; $display("FAIL basic_disp_fields got id=%h rd=%h op=%h exp 00 25 1234", rename_dispatch_robid, rename_dispatch_rd, rename_dispatch_op); end
    checks++; if (rename_dispatch_rs1_valid !== 1'b0 || rename_dispatch_rs1_tagval !== 32'h4) begin errors++; $display("FAIL basic_rs1 got v=%b t=%h exp v=0 t=4", rename_dispatch_rs1_valid, rename_dispatch_rs1_tagval); end
    checks++; if (rename_dispatch_rs2_valid !== 1'b1 || rename_dispatch_rs2_tagval !== 32'h0) begin errors++; $display("FAIL basic_rs2_zero got v=%b t=%h exp v=1 t=0", rename_dispatch_rs2_valid, rename_dispatch_rs2_tagval); end
    next_cycle();
    sample();
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", rename_dispatch_valid); end
    next_cycle();
  endtask

  // Hold dispatch for 3 cycles. Pulse a writeback that matches rs1's tag 0x04.
  task automatic test_wakeup(input logic err, input logic [7:0] exp_id);
    logic        exp_v;
    logic [31:0] exp_t;
    exp_v = ~err;
    exp_t = err ? 32'h4 : 32'hDEAD_BEEF;
    drive_decode(1'b1, 6'h22, 5'd5, 5'd6, 32'hCAFE_0000);
    next_cycle();
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    drive_rat(1'b0, 32'h4, 1'b1, 32'h55);
    dispatch_stall = 1'b1;
    sample();
    checks++; if (rename_stall !== 1'b1) begin errors++; $display("FAIL wake%0d_stall_c1 got %b exp 1", err, rename_stall); end
    checks++; if (rename_dispatch_rs1_valid !== 1'b0 || rename_dispatch_rs1_tagval !== 32'h4) begin errors++; $display("FAIL wake%0d_rs1_c1 got v=%b t=%h exp v=0 t=4", err, rename_dispatch_rs1_valid, rename_dispatch_rs1_tagval); end
    next_cycle();
    // The RAT bus now carries unrelated values. S1 must use its own registers.
    drive_rat(1'b1, 32'h77, 1'b0, 32'h66);
    wb_valid = 1'b1; wb_error = err; wb_robid = 8'h04; wb_result = 32'hDEAD_BEEF;
    sample();
    checks++; if (rename_stall !== 1'b1) begin errors++; $display("FAIL wake%0d_stall_c2 got %b exp 1", err, rename_stall); end
    checks++; if (rename_dispatch_rs1_valid !== exp_v || rename_dispatch_rs1_tagval !== exp_t) begin errors++; $display("FAIL wake%0d_rs1_pulse got v=%b t=%h exp v=%b t=%h", err, rename_dispatch_rs1_valid, rename_dispatch_rs1_tagval, exp_v, exp_t); end
    checks++; if (rename_dispatch_rs2_valid !== 1'b1 || rename_dispatch_rs2_tagval !== 32'h55) begin errors++; $display("FAIL wake%0d_rs2_held got v=%b t=%h exp v=1 t=55", err, rename_dispatch_rs2_valid, rename_dispatch_rs2_tagval); end
    next_cycle();
    wb_valid = 1'b0; wb_error = 1'b0;
    sample();
    checks++; if (rename_stall !== 1'b1 || rename_dispatch_valid !== 1'b1) begin errors++; $display("FAIL wake%0d_c3 got stall=%b dv=%b exp 1 1", err, rename_stall, rename_dispatch_valid); end
    checks++; if (rename_dispatch_rs1_valid !== exp_v || rename_dispatch_rs1_tagval !== exp_t) begin errors++; $display("FAIL wake%0d_rs1_held got v=%b t=%h exp v=%b t=%h", err, rename_dispatch_rs1_valid, rename_dispatch_rs1_tagval, exp_v, exp_t); end
    next_cycle();
    dispatch_stall = 1'b0;
    sample();
    checks++; if (rename_dispatch_valid !== 1'b1 || rename_stall !== 1'b0) begin errors++; $display("FAIL wake%0d_release got dv=%b stall=%b exp 1 0", err, rename_dispatch_valid, rename_stall); end
    checks++; if (rename_dispatch_robid !== exp_id) begin errors++; $display("FAIL wake%0d_robid got %h exp %h", err, rename_dispatch_robid, exp_id); end
    checks++; if (rename_dispatch_rs1_valid !== exp_v || rename_dispatch_rs1_tagval !== exp_t) begin errors++; $display("FAIL wake%0d_rs1_out got v=%b t=%h exp v=%b t=%h", err, rename_dispatch_rs1_valid, rename_dispatch_rs1_tagval, exp_v, exp_t); end
    next_cycle();
    sample();
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL wake%0d_once got %b exp 0", err, rename_dispatch_valid); end
    next_cycle();
  endtask

  // Flush to zero the counter, then run 257 accepts back to back.
  task automatic test_back_to_back();
    logic [8:0] i9;
    logic [7:0] prev;
    logic       exp_rat;
    rob_flush = 1'b1;
    next_cycle();
    rob_flush = 1'b0;
    drive_rat(1'b1, 32'h1, 1'b1, 32'h2);
    for (int i = 0; i < 257; i++) begin
      i9 = 9'(i);
      drive_decode(1'b1, i9[5:0], 5'd1, 5'd2, 32'(i));
      exp_rat = i9[5] && (i9[4:0] != 5'd0);
      sample();
      checks++; if (rename_rob_valid !== 1'b1 || rename_rob_robid !== i9[7:0] || rename_rob_rd !== i9[5:0]) begin errors++; $display("FAIL b2b_rob[%0d] got v=%b id=%h rd=%h exp v=1 id=%h rd=%h", i, rename_rob_valid, rename_rob_robid, rename_rob_rd, i9[7:0], i9[5:0]); end
      checks++; if (rename_rat_valid !== exp_rat) begin errors++; $display("FAIL b2b_rat_valid[%0d] got %b exp %b", i, rename_rat_valid, exp_rat); end
      if (i > 0) begin
        prev = 8'(i - 1);
        checks++; if (rename_dispatch_valid !== 1'b1 || rename_dispatch_robid !== prev) begin errors++; $display("FAIL b2b_disp[%0d] got v=%b id=%h exp v=1 id=%h", i, rename_dispatch_valid, rename_dispatch_robid, prev); end
      end
      next_cycle();
    end
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    sample();
    checks++; if (rename_dispatch_valid !== 1'b1 || rename_dispatch_robid !== 8'h00) begin errors++; $display("FAIL b2b_last got v=%b id=%h exp v=1 id=00", rename_dispatch_valid, rename_dispatch_robid); end
    next_cycle();
    sample();
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", rename_dispatch_valid); end
    next_cycle();
  endtask

  // After the stream the counter is 1, so the flush resets a nonzero value.
  task automatic test_flush();
    drive_decode(1'b1, 6'h21, 5'd1, 5'd2, 32'h10);
    next_cycle();
    drive_decode(1'b1, 6'h23, 5'd1, 5'd2, 32'h11);
    rob_flush = 1'b1;
    sample();
    checks++; if (rename_rat_valid !== 1'b0 || rename_rob_valid !== 1'b0) begin errors++; $display("FAIL flush_writes got rat=%b rob=%b exp 0 0", rename_rat_valid, rename_rob_valid); end
    next_cycle();
    rob_flush = 1'b0;
    sample();
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL flush_disp_next got %b exp 0", rename_dispatch_valid); end
    checks++; if (rename_rob_valid !== 1'b1 || rename_rob_robid !== 8'h00) begin errors++; $display("FAIL flush_robid got v=%b id=%h exp v=1 id=00", rename_rob_valid, rename_rob_robid); end
    next_cycle();
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    sample();
    checks++; if (rename_dispatch_valid !== 1'b1 || rename_dispatch_robid !== 8'h00 || rename_dispatch_rd !== 6'h23) begin errors++; $display("FAIL flush_after got v=%b id=%h rd=%h exp 1 00 23", rename_dispatch_valid, rename_dispatch_robid, rename_dispatch_rd); end
    next_cycle();
  endtask

  // The counter is 1 here.
  task automatic test_rob_full();
    drive_decode(1'b1, 6'h24, 5'd1, 5'd2, 32'h20);
    next_cycle();
    drive_decode(1'b1, 6'h26, 5'd1, 5'd2, 32'h21);
    rob_rename_full = 1'b1;
    sample();
    checks++; if (rename_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", rename_stall); end
    checks++; if (rename_rob_valid !== 1'b0 || rename_rat_valid !== 1'b0) begin errors++; $display("FAIL full_no_accept got rob=%b rat=%b exp 0 0", rename_rob_valid, rename_rat_valid); end
    checks++; if (rename_dispatch_valid !== 1'b1 || rename_dispatch_robid !== 8'h01) begin errors++; $display("FAIL full_drain got v=%b id=%h exp 1 01", rename_dispatch_valid, rename_dispatch_robid); end
    next_cycle();
    sample();
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", rename_dispatch_valid); end
    next_cycle();
    rob_rename_full = 1'b0;
    sample();
    checks++; if (rename_rob_valid !== 1'b1 || rename_rob_robid !== 8'h02) begin errors++; $display("FAIL full_resume got v=%b id=%h exp 1 02", rename_rob_valid, rename_rob_robid); end
    next_cycle();
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    next_cycle();
  endtask

  // A reset that arrives while S1 is full drops the instruction.
  task automatic test_reset_mid();
    drive_decode(1'b1, 6'h27, 5'd1, 5'd2, 32'h30);
    next_cycle();
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    rst = 1'b1;
    sample();
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL rstmid_disp got %b exp 0", rename_dispatch_valid); end
    next_cycle();
    rst = 1'b0;
    drive_decode(1'b1, 6'h28, 5'd1, 5'd2, 32'h31);
    sample();
    checks++; if (rename_dispatch_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b exp 0", rename_dispatch_valid); end
    checks++; if (rename_rob_robid !== 8'h00) begin errors++; $display("FAIL rstmid_robid got %h exp 00", rename_rob_robid); end
    next_cycle();
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    drive_decode(1'b0, 6'h0, 5'd0, 5'd0, 32'h0);
    drive_rat(1'b0, 32'h0, 1'b0, 32'h0);
    rob_rename_full = 1'b0; rob_flush = 1'b0;
    wb_valid = 1'b0; wb_error = 1'b0; wb_robid = 8'h0; wb_result = 32'h0;
    dispatch_stall = 1'b0;
    next_cycle();
    test_reset();
    test_basic();
    test_wakeup(1'b0, 8'h01);
    test_wakeup(1'b1, 8'h02);
    test_back_to_back();
    test_flush();
    test_rob_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
